// File: rtl/sound_pkg.sv
// Shared constants, source encodings and FSM states
// for the square-wave note scheduler.
package sound_pkg;

  localparam logic [5:0] BGM_BASE  = 6'd0;
  localparam logic [5:0] HIT_BASE  = 6'd48;
  localparam logic [5:0] MISS_BASE = 6'd56;
  localparam logic [4:0] END_CODE  = 5'd31;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_BGM  = 2'd1;
  localparam logic [1:0] SRC_HIT  = 2'd2;
  localparam logic [1:0] SRC_MISS = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_PLAY,
    S_GAP
  } state_t;

  function automatic logic [7:0] rom_word(
    input logic [4:0] code,
    input logic [2:0] dur
  );
    return {code, dur};
  endfunction

endpackage

// File: rtl/sound_scheduler_rom.sv
// 64x8 synchronous melody ROM: {code[4:0], dur[2:0]} per word.
// Unused words read as END so a runaway address stops a melody.
module melody_rom
  import sound_pkg::*;
(
  input  logic       clk,
  input  logic [5:0] addr,
  output logic [7:0] data
);

  always_ff @(posedge clk) begin
    case (addr)
      6'd0:    data <= rom_word(5'd5, 3'd0);
      6'd1:    data <= rom_word(5'd9, 3'd1);
      6'd2:    data <= rom_word(5'd12, 3'd0);
      6'd3:    data <= rom_word(5'd3, 3'd2);
      6'd48:   data <= rom_word(5'd16, 3'd1);
      6'd49:   data <= rom_word(5'd19, 3'd3);
      6'd56:   data <= rom_word(5'd6, 3'd2);
      6'd57:   data <= rom_word(5'd1, 3'd5);
      default: data <= rom_word(END_CODE, 3'd0);
    endcase
  end

endmodule

// File: rtl/sound_scheduler.sv
// Note sequencer: BGM loop plus HIT/MISS jingles,
// fixed priority MISS > HIT > BGM with BGM resume.
module sound_scheduler
  import sound_pkg::*;
#(
  parameter int TICK_DIV  = 6250000,
  parameter int GAP_TICKS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bgm_en,
  input  logic       hit_req,
  input  logic       miss_req,
  output logic [4:0] note,
  output logic       busy,
  output logic [1:0] src,
  output logic       jingle_done
);

  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [2:0] GAP_LAST = 3'(GAP_TICKS - 1);

  state_t state, state_n;
  logic [1:0] src_n, req_lvl;
  logic [5:0] cur_addr, addr_n;
  logic [5:0] bgm_addr, bgm_n;
  logic [5:0] rom_addr;
  logic [7:0] rom_data;
  logic [4:0] rom_code, note_n;
  logic [2:0] rom_dur;
  logic [DW-1:0] div, div_n;
  logic [2:0] ticks, ticks_n;
  logic [2:0] dur, dur_n;
  logic done_n, tick_end, preempt;

  assign rom_code = rom_data[7:3];
  assign rom_dur  = rom_data[2:0];
  assign tick_end = (div == DIV_LAST);
  assign busy     = (state != S_IDLE);

  assign req_lvl = miss_req ? SRC_MISS :
                   hit_req  ? SRC_HIT  : SRC_NONE;
  assign preempt = (req_lvl != SRC_NONE) && (req_lvl >= src);

  melody_rom u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (rom_data)
  );

  always_comb begin
    state_n = state;
    src_n   = src;
    addr_n  = cur_addr;
    bgm_n   = bgm_addr;
    div_n   = div;
    ticks_n = ticks;
    dur_n   = dur;
    done_n  = 1'b0;

    if (state == S_PLAY || state == S_GAP) begin
      if (tick_end) begin
        div_n   = '0;
        ticks_n = ticks + 3'd1;
      end else begin
        div_n = div + 1'b1;
      end
    end

    unique case (state)
      S_IDLE: begin
        if (bgm_en) begin
          state_n = S_FETCH;
          src_n   = SRC_BGM;
          addr_n  = bgm_addr;
        end
      end
      S_FETCH: begin
        div_n   = '0;
        ticks_n = '0;
        if (rom_code != END_CODE) begin
          state_n = S_PLAY;
          dur_n   = rom_dur;
        end else if (src == SRC_BGM) begin
          addr_n = BGM_BASE;
          bgm_n  = BGM_BASE;
        end else begin
          done_n = 1'b1;
          if (bgm_en) begin
            src_n  = SRC_BGM;
            addr_n = bgm_addr;
          end else begin
            state_n = S_IDLE;
            src_n   = SRC_NONE;
          end
        end
      end
      S_PLAY: begin
        if (tick_end && ticks == dur) begin
          state_n = S_GAP;
          div_n   = '0;
          ticks_n = '0;
        end
      end
      S_GAP: begin
        // ROM already holds the next word; a BGM END wraps here
        if (tick_end && ticks == GAP_LAST) begin
          state_n = S_FETCH;
          if (src == SRC_BGM && rom_code == END_CODE)
            addr_n = BGM_BASE;
          else
            addr_n = cur_addr + 6'd1;
          if (src == SRC_BGM)
            bgm_n = addr_n;
        end
      end
    endcase

    if (src == SRC_BGM && !bgm_en) begin
      state_n = S_IDLE;
      src_n   = SRC_NONE;
      bgm_n   = BGM_BASE;
    end

    if (preempt) begin
      state_n = S_FETCH;
      src_n   = req_lvl;
      addr_n  = (req_lvl == SRC_MISS) ? MISS_BASE : HIT_BASE;
      done_n  = 1'b0;
    end

    note_n = '0;
    if (state_n == S_PLAY)
      note_n = (state == S_FETCH) ? rom_code : note;

    rom_addr = (state_n == S_FETCH) ? addr_n : cur_addr + 6'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      src         <= SRC_NONE;
      cur_addr    <= BGM_BASE;
      bgm_addr    <= BGM_BASE;
      div         <= '0;
      ticks       <= '0;
      dur         <= '0;
      note        <= '0;
      jingle_done <= 1'b0;
    end else begin
      state       <= state_n;
      src         <= src_n;
      cur_addr    <= addr_n;
      bgm_addr    <= bgm_n;
      div         <= div_n;
      ticks       <= ticks_n;
      dur         <= dur_n;
      note        <= note_n;
      jingle_done <= done_n;
    end
  end

endmodule
